// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode-class and mux-select encodings shared by the main control
package mc_ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;
    typedef enum logic [2:0] {
        C_R     = 3'd0,
        C_ADDI  = 3'd1,
        C_LOAD  = 3'd2,
        C_STORE = 3'd3,
        C_BEQ   = 3'd4,
        C_J     = 3'd5,
        C_ILL   = 3'd6
    } class_e;
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_LH   = 6'h21;
    localparam logic [5:0] OP_LHU  = 6'h25;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
endpackage

// File: rtl/mc_opcode_class.sv
// mc_opcode_class: combinational opcode classifier for the main control
//   opcode_i    : IR opcode field
//   cls_o       : instruction class (class_e encoding)
//   ld_half_o   : opcode is a halfword load
//   ld_signed_o : opcode is a sign-extending halfword load
//   legal_o     : opcode is one of the supported instructions
module mc_opcode_class
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic [2:0]          cls_o,
    output logic                ld_half_o,
    output logic                ld_signed_o,
    output logic                legal_o
);
    // Constants are zero-extended, so any set bit above bit 5 fails every match.
    logic is_r, is_addi, is_lw, is_lh, is_lhu, is_sw, is_beq, is_j;
    assign is_r    = opcode_i == OPCODE_W'(OP_R);
    assign is_addi = opcode_i == OPCODE_W'(OP_ADDI);
    assign is_lw   = opcode_i == OPCODE_W'(OP_LW);
    assign is_lh   = opcode_i == OPCODE_W'(OP_LH);
    assign is_lhu  = opcode_i == OPCODE_W'(OP_LHU);
    assign is_sw   = opcode_i == OPCODE_W'(OP_SW);
    assign is_beq  = opcode_i == OPCODE_W'(OP_BEQ);
    assign is_j    = opcode_i == OPCODE_W'(OP_J);
    assign cls_o = is_r                    ? C_R     :
                   is_addi                 ? C_ADDI  :
                   (is_lw | is_lh | is_lhu) ? C_LOAD  :
                   is_sw                   ? C_STORE :
                   is_beq                  ? C_BEQ   :
                   is_j                    ? C_J     : C_ILL;
    assign ld_half_o   = is_lh | is_lhu;
    assign ld_signed_o = is_lh;
    assign legal_o     = cls_o != C_ILL;
endmodule

// File: rtl/mc_main_control.sv
// mc_main_control: multi-cycle MIPS main control FSM (fetch/decode/execute/memory/write-back)
//   clk, reset        : rising-edge clock, asynchronous active-low reset
//   opcode            : IR opcode field, valid from DECODE onward
//   mem_ready         : memory completes the current access this cycle
//   pc_write(_cond)   : PC load, unconditional / on ALU zero
//   ir_write, iord    : IR load, memory address select (1 = ALUOut)
//   mem_read/write    : memory requests
//   mem_to_reg, reg_dest, reg_write : register-file write-back controls
//   alu_src_a/b, alu_op, pc_source  : datapath mux and ALU-control selects
//   ld_half, ld_signed: halfword-load qualifiers
//   illegal_op        : one-cycle pulse in DECODE on an unknown opcode
//   state             : current state code
module mc_main_control
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                ir_write,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                reg_dest,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [1:0]          pc_source,
    output logic                ld_half,
    output logic                ld_signed,
    output logic                illegal_op,
    output logic [3:0]          state
);
    state_e     state_q, state_d;
    logic [2:0] cls;
    logic       half, signed_ld, legal;
    mc_opcode_class #(.OPCODE_W(OPCODE_W)) u_class (
        .opcode_i    (opcode),
        .cls_o       (cls),
        .ld_half_o   (half),
        .ld_signed_o (signed_ld),
        .legal_o     (legal)
    );
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   state_d = cls == C_R                            ? S_EXEC_R   :
                                  cls == C_ADDI                         ? S_EXEC_I   :
                                  (cls == C_LOAD || cls == C_STORE)     ? S_MEM_ADDR :
                                  cls == C_BEQ                          ? S_BRANCH   :
                                  cls == C_J                            ? S_JUMP     : S_FETCH;
            S_MEM_ADDR: state_d = cls == C_STORE ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC_R:   state_d = S_R_WB;
            S_EXEC_I:   state_d = S_I_WB;
            default:    state_d = S_FETCH;
        endcase
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) state_q <= S_FETCH;
        else state_q <= state_d;
    // Every output is qualified by the reset level so that asserting reset
    // silences the datapath at once, including FETCH's own decodes.
    logic run, st_fetch, st_mem_rd, st_mem_wr, st_mem_wb, st_br, st_j;
    assign run       = reset;
    assign st_fetch  = run && state_q == S_FETCH;
    assign st_mem_rd = run && state_q == S_MEM_RD;
    assign st_mem_wr = run && state_q == S_MEM_WR;
    assign st_mem_wb = run && state_q == S_MEM_WB;
    assign st_br     = run && state_q == S_BRANCH;
    assign st_j      = run && state_q == S_JUMP;
    assign ir_write      = st_fetch && mem_ready;
    assign pc_write      = (st_fetch && mem_ready) || st_j;
    assign pc_write_cond = st_br;
    assign iord          = st_mem_rd || st_mem_wr;
    assign mem_read      = st_fetch || st_mem_rd;
    assign mem_write     = st_mem_wr;
    assign mem_to_reg    = st_mem_wb;
    assign reg_dest      = run && state_q == S_R_WB;
    assign reg_write     = st_mem_wb || (run && (state_q == S_R_WB || state_q == S_I_WB));
    assign alu_src_a     = run && (state_q == S_MEM_ADDR || state_q == S_EXEC_R ||
                                   state_q == S_EXEC_I   || state_q == S_BRANCH);
    assign alu_src_b = !run                                            ? SRCB_REG    :
                       state_q == S_FETCH                              ? SRCB_FOUR   :
                       state_q == S_DECODE                             ? SRCB_IMM_SH :
                       (state_q == S_MEM_ADDR || state_q == S_EXEC_I)  ? SRCB_IMM    : SRCB_REG;
    assign alu_op = !run                  ? ALUOP_W'(ALU_ADD)   :
                    state_q == S_EXEC_R   ? ALUOP_W'(ALU_FUNCT) :
                    state_q == S_BRANCH   ? ALUOP_W'(ALU_SUB)   : ALUOP_W'(ALU_ADD);
    assign pc_source  = st_br ? PCSRC_ALUOUT : st_j ? PCSRC_JUMP : PCSRC_ALU;
    // Qualifiers follow the IR opcode, which stays stable through the load.
    assign ld_half    = (st_mem_rd || st_mem_wb) && half;
    assign ld_signed  = (st_mem_rd || st_mem_wb) && signed_ld;
    assign illegal_op = run && state_q == S_DECODE && !legal;
    assign state      = state_q;
endmodule

// File: tb/tb_mc_main_control.sv
// tb_mc_main_control: directed table-driven check of the multi-cycle main control
module tb_mc_main_control;
    typedef struct packed {
        logic       pcw, pcwc, irw, iord, mrd, mwr, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, psrc;
        logic       lh, ls, ill;
        logic [3:0] st;
    } out_t;
    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       rdy;
        out_t       e;
    } vec_t;
    localparam out_t O_RST    = '{default: '0};
    localparam out_t O_F_RDY  = '{pcw: 1'b1, irw: 1'b1, mrd: 1'b1, asb: 2'd1, st: 4'd0, default: '0};
    localparam out_t O_F_WAIT = '{mrd: 1'b1, asb: 2'd1, st: 4'd0, default: '0};
    localparam out_t O_DEC    = '{asb: 2'd3, st: 4'd1, default: '0};
    localparam out_t O_DECILL = '{asb: 2'd3, ill: 1'b1, st: 4'd1, default: '0};
    localparam out_t O_EXR    = '{asa: 1'b1, aop: 2'd2, st: 4'd6, default: '0};
    localparam out_t O_RWB    = '{rdst: 1'b1, rw: 1'b1, st: 4'd7, default: '0};
    localparam out_t O_EXI    = '{asa: 1'b1, asb: 2'd2, st: 4'd8, default: '0};
    localparam out_t O_IWB    = '{rw: 1'b1, st: 4'd9, default: '0};
    localparam out_t O_MADDR  = '{asa: 1'b1, asb: 2'd2, st: 4'd2, default: '0};
    localparam out_t O_MRD_LH = '{iord: 1'b1, mrd: 1'b1, lh: 1'b1, ls: 1'b1, st: 4'd3, default: '0};
    localparam out_t O_MWB_LH = '{m2r: 1'b1, rw: 1'b1, lh: 1'b1, ls: 1'b1, st: 4'd4, default: '0};
    localparam out_t O_MRD_HU = '{iord: 1'b1, mrd: 1'b1, lh: 1'b1, st: 4'd3, default: '0};
    localparam out_t O_MWB_HU = '{m2r: 1'b1, rw: 1'b1, lh: 1'b1, st: 4'd4, default: '0};
    localparam out_t O_MRD_LW = '{iord: 1'b1, mrd: 1'b1, st: 4'd3, default: '0};
    localparam out_t O_MWB_LW = '{m2r: 1'b1, rw: 1'b1, st: 4'd4, default: '0};
    localparam out_t O_MWR    = '{iord: 1'b1, mwr: 1'b1, st: 4'd5, default: '0};
    localparam out_t O_BR     = '{asa: 1'b1, pcwc: 1'b1, aop: 2'd1, psrc: 2'd1, st: 4'd10, default: '0};
    localparam out_t O_J      = '{pcw: 1'b1, psrc: 2'd2, st: 4'd11, default: '0};
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write;
    logic       mem_to_reg, reg_dest, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       ld_half, ld_signed, illegal_op;
    logic [3:0] state;
    int         total = 0;
    int         bad = 0;
    vec_t       tv[$];
    always #5 clk = ~clk;
    mc_main_control #(.OPCODE_W(6), .ALUOP_W(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dest      (reg_dest),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .ld_half       (ld_half),
        .ld_signed     (ld_signed),
        .illegal_op    (illegal_op),
        .state         (state)
    );
    task automatic chk(input string nm, input out_t e);
        out_t got;
        got = '{pcw: pc_write, pcwc: pc_write_cond, irw: ir_write, iord: iord,
                mrd: mem_read, mwr: mem_write, m2r: mem_to_reg, rdst: reg_dest,
                rw: reg_write, asa: alu_src_a, asb: alu_src_b, aop: alu_op,
                psrc: pc_source, lh: ld_half, ls: ld_signed, ill: illegal_op, st: state};
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, e);
        end
    endtask
    task automatic step(input logic r, input logic [5:0] op, input logic rdy, input out_t e, input string nm);
        reset = r;
        opcode = op;
        mem_ready = rdy;
        #1;
        chk(nm, e);
        @(negedge clk);
    endtask
    initial begin
        reset = 1'b0;
        opcode = 6'h00;
        mem_ready = 1'b1;
        tv.push_back('{1'b0, 6'h00, 1'b1, O_RST});
        tv.push_back('{1'b0, 6'h23, 1'b1, O_RST});
        tv.push_back('{1'b1, 6'h00, 1'b1, O_F_RDY});
        tv.push_back('{1'b1, 6'h00, 1'b1, O_DEC});
        tv.push_back('{1'b1, 6'h00, 1'b1, O_EXR});
        tv.push_back('{1'b1, 6'h00, 1'b1, O_RWB});
        tv.push_back('{1'b1, 6'h08, 1'b1, O_F_RDY});
        tv.push_back('{1'b1, 6'h08, 1'b1, O_DEC});
        tv.push_back('{1'b1, 6'h08, 1'b1, O_EXI});
        tv.push_back('{1'b1, 6'h08, 1'b1, O_IWB});
        tv.push_back('{1'b1, 6'h21, 1'b1, O_F_RDY});
        tv.push_back('{1'b1, 6'h21, 1'b1, O_DEC});
        tv.push_back('{1'b1, 6'h21, 1'b1, O_MADDR});
        tv.push_back('{1'b1, 6'h21, 1'b0, O_MRD_LH});
        tv.push_back('{1'b1, 6'h21, 1'b0, O_MRD_LH});
        tv.push_back('{1'b1, 6'h21, 1'b1, O_MRD_LH});
        tv.push_back('{1'b1, 6'h21, 1'b1, O_MWB_LH});
        tv.push_back('{1'b1, 6'h25, 1'b1, O_F_RDY});
        tv.push_back('{1'b1, 6'h25, 1'b1, O_DEC});
        tv.push_back('{1'b1, 6'h25, 1'b1, O_MADDR});
        tv.push_back('{1'b1, 6'h25, 1'b1, O_MRD_HU});
        tv.push_back('{1'b1, 6'h25, 1'b1, O_MWB_HU});
        tv.push_back('{1'b1, 6'h2B, 1'b0, O_F_WAIT});
        tv.push_back('{1'b1, 6'h2B, 1'b1, O_F_RDY});
        tv.push_back('{1'b1, 6'h2B, 1'b1, O_DEC});
        tv.push_back('{1'b1, 6'h2B, 1'b1, O_MADDR});
        tv.push_back('{1'b1, 6'h2B, 1'b1, O_MWR});
        tv.push_back('{1'b1, 6'h04, 1'b1, O_F_RDY});
        tv.push_back('{1'b1, 6'h04, 1'b1, O_DEC});
        tv.push_back('{1'b1, 6'h04, 1'b1, O_BR});
        tv.push_back('{1'b1, 6'h02, 1'b1, O_F_RDY});
        tv.push_back('{1'b1, 6'h02, 1'b1, O_DEC});
        tv.push_back('{1'b1, 6'h02, 1'b1, O_J});
        tv.push_back('{1'b1, 6'h3F, 1'b1, O_F_RDY});
        tv.push_back('{1'b1, 6'h3F, 1'b1, O_DECILL});
        tv.push_back('{1'b1, 6'h20, 1'b1, O_F_RDY});
        tv.push_back('{1'b1, 6'h20, 1'b0, O_DECILL});
        tv.push_back('{1'b1, 6'h2B, 1'b1, O_F_RDY});
        tv.push_back('{1'b1, 6'h2B, 1'b1, O_DEC});
        tv.push_back('{1'b1, 6'h2B, 1'b1, O_MADDR});
        tv.push_back('{1'b1, 6'h2B, 1'b0, O_MWR});
        tv.push_back('{1'b1, 6'h2B, 1'b1, O_MWR});
        @(negedge clk);
        for (int i = 0; i < tv.size(); i++)
            step(tv[i].rst, tv[i].op, tv[i].rdy, tv[i].e, $sformatf("vec%0d", i));
        step(1'b1, 6'h23, 1'b1, O_F_RDY, "lw_fetch");
        step(1'b1, 6'h23, 1'b1, O_DEC, "lw_decode");
        step(1'b1, 6'h23, 1'b1, O_MADDR, "lw_addr");
        step(1'b1, 6'h23, 1'b1, O_MRD_LW, "lw_rd");
        #1;
        chk("lw_wb", O_MWB_LW);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async", O_RST);
        @(posedge clk);
        #1;
        chk("rst_hold", O_RST);
        @(negedge clk);
        step(1'b1, 6'h00, 1'b1, O_F_RDY, "post_rst_fetch");
        step(1'b1, 6'h00, 1'b1, O_DEC, "post_rst_decode");
        step(1'b1, 6'h00, 1'b1, O_EXR, "post_rst_exec");
        step(1'b1, 6'h00, 1'b1, O_RWB, "post_rst_wb");
        step(1'b1, 6'h00, 1'b1, O_F_RDY, "post_rst_refetch");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mc_main_control.md
# mc_main_control

Multi-cycle main control unit for the MIPS datapath: a Moore/Mealy FSM that sequences each instruction through fetch, decode, execute, memory and write-back, replacing the single-cycle opcode decoder. It sits between the instruction register (source of `opcode`) and the shared datapath muxes, ALU control, register file and unified memory. Compared with the single-cycle decoder it adds memory wait-state handling, a jump instruction, halfword-load qualifiers and illegal-opcode reporting, with opcode and ALU-op widths parameterised.

## Interface
- `OPCODE_W`, 6: opcode field width; constants are zero-extended to this width.
- `ALUOP_W`, 2: width of `alu_op` toward ALU control.
- `clk` input 1: rising-edge clock.
- `reset` input 1: reset, asynchronous, active-low.
- `opcode` input OPCODE_W: IR opcode field, valid from DECODE onward.
- `mem_ready` input 1: memory completes the current read/write this cycle.
- `pc_write` output 1: unconditional PC load.
- `pc_write_cond` output 1: PC load if ALU zero (beq).
- `ir_write` output 1: load IR from memory data.
- `iord` output 1: memory address from ALUOut (1) or PC (0).
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `mem_to_reg` output 1: write-back from MDR (1) or ALUOut (0).
- `reg_dest` output 1: destination rd (1) or rt (0).
- `reg_write` output 1: register file write enable.
- `alu_src_a` output 1: ALU A from register A (1) or PC (0).
- `alu_src_b` output 2: 0 reg B, 1 constant 4, 2 sign-ext imm, 3 sign-ext imm<<2.
- `alu_op` output ALUOP_W: 0 add, 1 sub, 2 funct-decoded.
- `pc_source` output 2: 0 ALU result, 1 ALUOut, 2 jump target.
- `ld_half` / `ld_signed` output 1 each: halfword load / sign-extend load.
- `illegal_op` output 1: one-cycle pulse on unknown opcode.
- `state` output 4: current state code, for debug.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP.
- FETCH:
  - Drives `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=add, `pc_source`=0.
  - `ir_write` and `pc_write` assert only while `mem_ready`=1; the FSM holds in FETCH until `mem_ready`=1, then goes to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=3, `alu_op`=add (branch target precompute). Next state by opcode:
  - 0x00 → EXEC_R
  - 0x08 → EXEC_I
  - 0x23, 0x21, 0x25, 0x2B → MEM_ADDR
  - 0x04 → BRANCH
  - 0x02 → JUMP
  - any other opcode → FETCH, with `illegal_op`=1 this cycle.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=add; goes to MEM_WR for sw, otherwise MEM_RD.
- MEM_RD: `mem_read`=1, `iord`=1; holds until `mem_ready`, then MEM_WB.
- MEM_WR: `mem_write`=1, `iord`=1; holds until `mem_ready`, then FETCH.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dest`=0, then FETCH.
  - `ld_half`=1 for 0x21 and 0x25; `ld_signed`=1 for 0x21.
  - Both qualifiers are driven in MEM_RD and MEM_WB.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=2, then R_WB.
- R_WB: `reg_write`=1, `reg_dest`=1, `mem_to_reg`=0, then FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=add, then I_WB.
- I_WB: `reg_write`=1, `reg_dest`=0, `mem_to_reg`=0, then FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=sub, `pc_write_cond`=1, `pc_source`=1, then FETCH.
- JUMP: `pc_write`=1, `pc_source`=2, then FETCH.
- Any output not listed for a state is 0.
- Opcode matching compares all OPCODE_W bits; upper bits beyond 6 must be zero to match.

## Timing
- While `reset`=0 (asynchronous): state=FETCH and every output is 0, including FETCH's own decodes.
- First cycle after reset deassertion: FETCH outputs active.
- Cycle counts with zero wait states (`mem_ready` tied 1): R 4, addi 4, lw/lh/lhu 5, sw 4, beq 3, j 3, illegal 2.
- Each wait cycle adds exactly 1 cycle in FETCH, MEM_RD or MEM_WR.
- `mem_read`/`mem_write` stay asserted for the whole wait with stable `iord`.
- `ir_write`/`pc_write` in FETCH are Mealy on `mem_ready`. All other outputs are Moore, decoded from the registered state.
- Reset asserted mid-instruction aborts immediately; no partial `reg_write` or `mem_write` is issued after the reset edge.

## Structure
- Package `mc_ctrl_pkg`:
  - state enum
  - opcode constants (R, ADDI, LW, LH, LHU, SW, BEQ, J)
  - ALU-op constants
  - `alu_src_b` and `pc_source` encodings.
- Sub-module `mc_opcode_class`: combinational opcode → {class, ld_half, ld_signed, legal} classifier, used by the DECODE next-state logic and the load qualifiers.

## Test plan
- Reset, then R-type (0x00) with `mem_ready`=1:
  - States FETCH, DECODE, EXEC_R, R_WB, FETCH.
  - `reg_write`=1, `reg_dest`=1 only in cycle 4.
- lh (0x21) with `mem_ready` low for 2 cycles in MEM_RD:
  - 7 cycles total; `mem_read`=1 and `iord`=1 held for 3 cycles.
  - `ld_half`=1 and `ld_signed`=1; `reg_write` on the last cycle only.
- sw (0x2B) with 1 FETCH wait:
  - `ir_write` and `pc_write` pulse only in the second FETCH cycle.
  - `mem_write`=1 for exactly 1 cycle; `reg_write` never asserted.
- beq (0x04) then j (0x02):
  - beq: `pc_write_cond`=1 with `pc_source`=1, `alu_op`=1 in cycle 3.
  - j: `pc_write`=1 with `pc_source`=2 in cycle 3.
- Opcode 0x3F:
  - `illegal_op`=1 for one DECODE cycle, then FETCH.
  - No write enables asserted.
- `reset` pulsed low during MEM_WB of lw:
  - `reg_write` drops asynchronously.
  - After release the FSM starts in FETCH with all outputs 0 during reset.
